sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between two requesters: instruction fetch (port I) and the EXE-stage data port (port D).
- Grants address phases by fixed priority and holds a grant until addr_ok arrives.
- Records the owner of each accepted request in an in-order ID queue, so each data_ok/rdata response is steered back to the requester that issued it.
- Sits between the pipeline's inst/data SRAM-like interfaces and the downstream memory/bridge.

---
 rtl/sram_req_arbiter_pkg.sv | 22 ++
 rtl/sram_req_arbiter_if.sv | 44 ++++
 rtl/sram_req_arbiter_fifo.sv | 60 ++++++
 rtl/sram_req_arbiter.sv | 93 +++++++++
 tb/tb_sram_req_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants for the two-requester SRAM-like port arbiter:
// access sizes, requester IDs and arbitration FSM states.
package sram_req_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } arb_state_e;

  function automatic arb_state_e lock_state(input logic id);
    return (id == ID_D) ? ST_LOCK_D : ST_LOCK_I;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// Bundle of the upstream inst/data SRAM-like ports and the downstream port.
// The slave modport is the arbiter's view; master is the environment's view.
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req,     d_req;
  logic              i_wr,      d_wr;
  logic [1:0]        i_size,    d_size;
  logic [3:0]        i_wstrb,   d_wstrb;
  logic [ADDR_W-1:0] i_addr,    d_addr;
  logic [DATA_W-1:0] i_wdata,   d_wdata;
  logic              i_addr_ok, d_addr_ok;
  logic              i_data_ok, d_data_ok;
  logic [DATA_W-1:0] i_rdata,   d_rdata;

  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [3:0]        m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output i_addr_ok, i_data_ok, i_rdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport master (
    output i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/sram_req_arbiter_fifo.sv
// In-order queue of 1-bit requester IDs, one entry per accepted request,
// popped as downstream responses return.
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Fixed-priority (D over I) arbiter sharing one SRAM-like port; a grant is held
// until addr_ok, and responses are steered back through an in-order ID queue.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input logic               clk,
  input logic               resetn,
  sram_req_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic              owner;
  logic              owner_req;
  logic              m_req;
  logic              handshake;
  logic              full, empty, head;
  logic              rsp_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  // D wins in IDLE; a locked state pins the owner until addr_ok or cancel
  always_comb begin
    owner     = ID_I;
    owner_req = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      ST_LOCK_I: begin
        owner     = ID_I;
        owner_req = bus.i_req;
      end
      ST_LOCK_D: begin
        owner     = ID_D;
        owner_req = bus.d_req;
      end
      default: begin
        owner     = bus.d_req ? ID_D : ID_I;
        owner_req = bus.i_req | bus.d_req;
      end
    endcase

    if (!full) begin
      if (state_q == ST_IDLE) begin
        if (owner_req && !bus.m_addr_ok) state_d = lock_state(owner);
      end else if (!owner_req || bus.m_addr_ok) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign m_req     = owner_req & ~full;
  assign handshake = m_req & bus.m_addr_ok;
  assign m_addr    = (owner == ID_D) ? bus.d_addr  : bus.i_addr;
  assign m_wdata   = (owner == ID_D) ? bus.d_wdata : bus.i_wdata;

  assign bus.m_req   = m_req;
  assign bus.m_wr    = (owner == ID_D) ? bus.d_wr    : bus.i_wr;
  assign bus.m_size  = (owner == ID_D) ? bus.d_size  : bus.i_size;
  assign bus.m_wstrb = (owner == ID_D) ? bus.d_wstrb : bus.i_wstrb;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;

  assign bus.i_addr_ok = handshake & (owner == ID_I);
  assign bus.d_addr_ok = handshake & (owner == ID_D);

  // A response with nothing outstanding is dropped without popping
  assign rsp_valid     = bus.m_data_ok & ~empty;
  assign bus.i_data_ok = rsp_valid & (head == ID_I);
  assign bus.d_data_ok = rsp_valid & (head == ID_D);
  assign bus.i_rdata   = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (handshake),
    .din_i   (owner),
    .pop_i   (bus.m_data_ok),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: directed stimulus queues expected
// grants and responses; a negedge monitor pops and compares them.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_req_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_OUTST (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] val;
  } exp_t;

  exp_t hs_q[$];
  exp_t rsp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_hs(input logic id, input logic [31:0] a);
    exp_t e;
    e.id  = id;
    e.val = a;
    hs_q.push_back(e);
  endtask

  task automatic push_rsp(input logic id, input logic [31:0] d);
    exp_t e;
    e.id  = id;
    e.val = d;
    rsp_q.push_back(e);
  endtask

  // Monitor: every grant and every response must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (bus.m_req && bus.m_addr_ok) begin
        if (hs_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL hs_unexpected: grant addr 0x%0h, none expected", bus.m_addr);
        end else begin
          e = hs_q.pop_front();
          chk("hs_addr", bus.m_addr, e.val);
          chk("hs_i_addr_ok", 32'(bus.i_addr_ok), 32'(e.id == ID_I));
          chk("hs_d_addr_ok", 32'(bus.d_addr_ok), 32'(e.id == ID_D));
        end
      end else begin
        chk("no_hs_addr_ok", {30'b0, bus.i_addr_ok, bus.d_addr_ok}, 32'h0);
      end

      if (bus.i_data_ok || bus.d_data_ok) begin
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: i_data_ok %0b d_data_ok %0b, none expected",
                   bus.i_data_ok, bus.d_data_ok);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_i_data_ok", 32'(bus.i_data_ok), 32'(e.id == ID_I));
          chk("rsp_d_data_ok", 32'(bus.d_data_ok), 32'(e.id == ID_D));
          chk("rsp_i_rdata", bus.i_rdata, e.val);
          chk("rsp_d_rdata", bus.d_rdata, e.val);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.i_wr = 1'b0;  bus.d_wr = 1'b0;
    bus.i_size = SIZE_W; bus.d_size = SIZE_W;
    bus.i_wstrb = 4'h0; bus.d_wstrb = 4'h0;
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b0;
    bus.m_rdata = 32'h0;
  endtask

  task automatic set_i(input logic [31:0] a, input logic wr);
    bus.i_req = 1'b1; bus.i_addr = a; bus.i_wr = wr;
    bus.i_wdata = a ^ 32'hFFFF; bus.i_wstrb = wr ? 4'hF : 4'h0; bus.i_size = SIZE_W;
  endtask

  task automatic set_d(input logic [31:0] a, input logic wr);
    bus.d_req = 1'b1; bus.d_addr = a; bus.d_wr = wr;
    bus.d_wdata = a ^ 32'hFFFF; bus.d_wstrb = wr ? 4'hF : 4'h0; bus.d_size = SIZE_W;
  endtask

  task automatic respond(input logic [31:0] d, input logic id);
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = d;
    push_rsp(id, d);
    mid();
    next_cyc();
    bus.m_data_ok = 1'b0;
  endtask

  initial begin
    bus.i_addr = '0; bus.d_addr = '0; bus.i_wdata = '0; bus.d_wdata = '0;
    idle_inputs();
    resetn = 1'b0;
    next_cyc();
    next_cyc();
    mid();
    chk("rst_m_req", 32'(bus.m_req), 32'h0);
    chk("rst_addr_ok", {30'b0, bus.i_addr_ok, bus.d_addr_ok}, 32'h0);
    chk("rst_data_ok", {30'b0, bus.i_data_ok, bus.d_data_ok}, 32'h0);
    next_cyc();
    resetn = 1'b1;
    bus.m_data_ok = 1'b1;
    mid();
    chk("rst_empty_data_ok", {30'b0, bus.i_data_ok, bus.d_data_ok}, 32'h0);
    next_cyc();
    idle_inputs();

    // Priority: D first, then I
    set_i(32'h1000, 1'b0);
    set_d(32'h2000, 1'b0);
    bus.m_addr_ok = 1'b1;
    push_hs(ID_D, 32'h2000);
    mid();
    chk("t1_m_addr_d", bus.m_addr, 32'h2000);
    next_cyc();
    bus.d_req = 1'b0;
    push_hs(ID_I, 32'h1000);
    mid();
    chk("t1_m_addr_i", bus.m_addr, 32'h1000);
    next_cyc();
    idle_inputs();
    respond(32'h11, ID_D);
    respond(32'h22, ID_I);

    // Lock on I while D rises
    set_i(32'h1000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_d(32'h2000, 1'b0);
      mid();
      chk("t2_lock_addr", bus.m_addr, 32'h1000);
      chk("t2_d_addr_ok", 32'(bus.d_addr_ok), 32'h0);
      next_cyc();
    end
    bus.m_addr_ok = 1'b1;
    push_hs(ID_I, 32'h1000);
    mid();
    next_cyc();
    bus.i_req = 1'b0;
    push_hs(ID_D, 32'h2000);
    mid();
    next_cyc();
    idle_inputs();
    respond(32'h33, ID_I);
    respond(32'h44, ID_D);

    // I, D(write), I then in-order responses
    set_i(32'h100, 1'b0);
    bus.m_addr_ok = 1'b1;
    push_hs(ID_I, 32'h100);
    mid();
    next_cyc();
    bus.i_req = 1'b0;
    set_d(32'h200, 1'b1);
    push_hs(ID_D, 32'h200);
    mid();
    chk("t3_m_wr_d", 32'(bus.m_wr), 32'h1);
    chk("t3_m_wstrb", 32'(bus.m_wstrb), 32'hF);
    chk("t3_m_wdata", bus.m_wdata, 32'h200 ^ 32'hFFFF);
    next_cyc();
    bus.d_req = 1'b0;
    set_i(32'h104, 1'b0);
    push_hs(ID_I, 32'h104);
    mid();
    chk("t3_m_wr_i", 32'(bus.m_wr), 32'h0);
    next_cyc();
    idle_inputs();
    respond(32'hA, ID_I);
    respond(32'hB, ID_D);
    respond(32'hC, ID_I);

    // Fill the queue, then a pending 5th request waits for one response
    for (int k = 0; k < 4; k++) begin
      set_i(32'h400 + 32'(4 * k), 1'b0);
      bus.m_addr_ok = 1'b1;
      push_hs(ID_I, 32'h400 + 32'(4 * k));
      mid();
      next_cyc();
    end
    bus.i_req = 1'b0;
    set_d(32'h500, 1'b0);
    bus.m_addr_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("t4_full_m_req", 32'(bus.m_req), 32'h0);
      chk("t4_full_addr_ok", {30'b0, bus.i_addr_ok, bus.d_addr_ok}, 32'h0);
      next_cyc();
    end
    bus.m_data_ok = 1'b1;
    bus.m_rdata = 32'h1;
    push_rsp(ID_I, 32'h1);
    mid();
    chk("t4_pop_cycle_m_req", 32'(bus.m_req), 32'h0);
    next_cyc();
    bus.m_data_ok = 1'b0;
    push_hs(ID_D, 32'h500);
    mid();
    chk("t4_after_pop_m_req", 32'(bus.m_req), 32'h1);
    next_cyc();
    idle_inputs();
    respond(32'h2, ID_I);
    respond(32'h3, ID_I);
    respond(32'h4, ID_I);
    respond(32'h5, ID_D);

    // Steady push+pop at count 2 across 9 requests (pointer wrap)
    for (int j = 0; j < 9; j++) begin
      logic id;
      id = (j % 2 == 1) ? ID_D : ID_I;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      if (id == ID_D) set_d(32'h600 + 32'(4 * j), 1'b0);
      else            set_i(32'h600 + 32'(4 * j), 1'b0);
      bus.m_addr_ok = 1'b1;
      push_hs(id, 32'h600 + 32'(4 * j));
      if (j >= 2) begin
        bus.m_data_ok = 1'b1;
        bus.m_rdata = 32'h700 + 32'(j - 2);
        push_rsp(((j - 2) % 2 == 1) ? ID_D : ID_I, 32'h700 + 32'(j - 2));
      end else begin
        bus.m_data_ok = 1'b0;
      end
      mid();
      chk("t5_m_req", 32'(bus.m_req), 32'h1);
      next_cyc();
    end
    idle_inputs();
    respond(32'h707, ID_D);
    respond(32'h708, ID_I);

    // LOCK_D cancelled: no queue entry, I granted afterwards
    set_d(32'h800, 1'b0);
    mid();
    chk("t6_m_addr_d", bus.m_addr, 32'h800);
    next_cyc();
    bus.d_req = 1'b0;
    set_i(32'h900, 1'b0);
    bus.m_addr_ok = 1'b1;
    mid();
    chk("t6_cancel_m_req", 32'(bus.m_req), 32'h0);
    chk("t6_cancel_i_addr_ok", 32'(bus.i_addr_ok), 32'h0);
    next_cyc();
    push_hs(ID_I, 32'h900);
    mid();
    next_cyc();
    idle_inputs();
    respond(32'h55, ID_I);
    bus.m_data_ok = 1'b1;
    bus.m_rdata = 32'h66;
    mid();
    chk("t6_empty_data_ok", {30'b0, bus.i_data_ok, bus.d_data_ok}, 32'h0);
    next_cyc();
    idle_inputs();

    // Reset with one request outstanding clears the queue
    set_i(32'hA00, 1'b0);
    bus.m_addr_ok = 1'b1;
    push_hs(ID_I, 32'hA00);
    mid();
    next_cyc();
    idle_inputs();
    resetn = 1'b0;
    mid();
    next_cyc();
    resetn = 1'b1;
    bus.m_data_ok = 1'b1;
    bus.m_rdata = 32'h99;
    mid();
    chk("t7_post_rst_data_ok", {30'b0, bus.i_data_ok, bus.d_data_ok}, 32'h0);
    next_cyc();
    idle_inputs();
    next_cyc();

    chk("end_hs_q_left", 32'(hs_q.size()), 32'h0);
    chk("end_rsp_q_left", 32'(rsp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
